// File: rtl/adder8_pkg.sv
// adder8_pkg
//   Shared widths and types for the adder8 user design.
//   WIDTH  : operand / sum width (the pin frame fixes this at 8)
//   GROUP  : width of one carry-lookahead group
//   word_t : one operand or sum word
package adder8_pkg;

    localparam int WIDTH = 8;
    localparam int GROUP = 4;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/adder8_cla4.sv
// cla4
//   4-bit carry-lookahead group. Produces the group sum for a given carry-in,
//   together with group generate/propagate for the next lookahead level.
//   Ports:
//     a[3:0], b[3:0] : operand nibbles
//     cin            : carry into bit 0 of the group
//     s[3:0]         : nibble sum
//     G              : group generate (carry out of the group regardless of cin)
//     P              : group propagate (cin passes straight through the group)
module cla4
    import adder8_pkg::*;
(
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             G,
    output logic             P
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is a flat sum-of-products of g/p and cin; none depends on
    // another internal carry, so there is no ripple inside the group.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign s = w_p ^ w_c;

    assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign P = &w_p;

endmodule

// File: rtl/adder8.sv
// adder8
//   8-bit unsigned carry-lookahead adder in the user-project pin frame.
//   uo_out = (ui_in + uio_in) mod 256, purely combinational, zero latency.
//   Ports:
//     clk     : frame clock, unused
//     rst     : frame synchronous active-high reset, unused (no state exists)
//     ui_in   : operand A
//     uo_out  : sum A + B, low 8 bits
//     uio_in  : operand B
//     uio_out : tied 8'h00
//     uio_oe  : tied 8'h00, all uio pins are inputs
//     ena     : design-selected flag, ignored
module adder8
    import adder8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    word_t w_a;
    word_t w_b;
    word_t w_sum;
    logic  w_cin;
    logic  w_g0;
    logic  w_p0;
    logic  w_g1;
    logic  w_p1;
    logic  w_c4;
    logic  w_cout;

    assign w_a   = ui_in;
    assign w_b   = uio_in;
    assign w_cin = 1'b0;

    cla4 u_cla_lo (
        .a   (w_a[GROUP-1:0]),
        .b   (w_b[GROUP-1:0]),
        .cin (w_cin),
        .s   (w_sum[GROUP-1:0]),
        .G   (w_g0),
        .P   (w_p0)
    );

    cla4 u_cla_hi (
        .a   (w_a[WIDTH-1:GROUP]),
        .b   (w_b[WIDTH-1:GROUP]),
        .cin (w_c4),
        .s   (w_sum[WIDTH-1:GROUP]),
        .G   (w_g1),
        .P   (w_p1)
    );

    // Second-level lookahead across the two nibble groups.
    assign w_c4   = w_g0 | (w_p0 & w_cin);
    assign w_cout = w_g1 | (w_p1 & w_c4);

    assign uo_out  = w_sum;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Frame inputs with no function here, plus the carry-out that is not
    // brought to a pin.
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, ena, w_cout};

endmodule

// File: tb/tb_adder8.sv
module tb_adder8;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        bit         chk_cout;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    adder8 dut (
        .clk     (clk),
        .rst     (rst),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, split into 8-bit result and carry.
    task automatic apply(input int a, input int b, input string name, input bit chk_cout);
        exp_t e;
        int   full;
        full       = a + b;
        e.sum      = 8'(full % 256);
        e.cout     = (full > 255);
        e.chk_cout = chk_cout;
        e.name     = name;
        ui_in  = 8'(a);
        uio_in = 8'(b);
        exp_q.push_back(e);
        #2;
    endtask

    // Monitor: the datapath is combinational, so the output is "presented"
    // as soon as stimulus is issued; sample it 1 ns later.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() > 0);
            #1;
            e = exp_q.pop_front();
            total++;
            if (uo_out !== e.sum) begin
                bad++;
                $display("FAIL %s: A=%02h B=%02h uo_out=%02h expected=%02h",
                         e.name, ui_in, uio_in, uo_out, e.sum);
            end
            total++;
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                bad++;
                $display("FAIL %s_tieoff: uio_out=%02h uio_oe=%02h expected=00/00",
                         e.name, uio_out, uio_oe);
            end
            if (e.chk_cout) begin
                total++;
                if (dut.w_cout !== e.cout) begin
                    bad++;
                    $display("FAIL %s_cout: cout=%0b expected=%0b", e.name, dut.w_cout, e.cout);
                end
            end
        end
    end

    initial begin
        rst    = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #3;

        apply(8'h00, 8'h00, "zero",      1'b1);
        apply(8'h0C, 8'h07, "basic",     1'b1);
        apply(8'hF0, 8'h0F, "no_carry",  1'b1);
        apply(8'hAA, 8'h55, "alt_prop",  1'b1);
        apply(8'hFF, 8'h01, "full_wrap", 1'b1);
        apply(8'h80, 8'h80, "msb_carry", 1'b1);
        apply(8'h0F, 8'h01, "nib_carry", 1'b1);
        apply(8'hFF, 8'hFF, "max_max",   1'b1);

        // Robustness: reset pulses and ena drops must not disturb the sum.
        apply(8'h5A, 8'h3C, "pre_rst", 1'b1);
        @(negedge clk);
        rst = 1'b1;
        apply(8'h5A, 8'h3C, "in_rst", 1'b1);
        @(posedge clk);
        #1;
        apply(8'hC3, 8'h7E, "in_rst_edge", 1'b1);
        ena = 1'b0;
        apply(8'hC3, 8'h7E, "ena_low_rst", 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(8'h91, 8'h2D, "ena_low", 1'b1);
        @(posedge clk);
        #1;
        ena = 1'b1;
        apply(8'h91, 8'h2D, "ena_back", 1'b1);

        for (int i = 0; i < 200; i++)
            apply(int'($urandom_range(255)), int'($urandom_range(255)), "random", 1'b1);

        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++)
                apply(a, b, "exhaustive", 1'b0);

        for (int t = 0; t < 100 && exp_q.size() > 0; t++)
            #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
